branch_predictor: RTL and testbench

//  Fetch-stage next-PC generator that sits directly upstream of the PC register.
//  It does a same-cycle lookup of the current fetch PC in a direct-mapped BTB with
//  2-bit saturating counters, then drives the address the PC register loads next.
//  The EX stage reports each resolved branch back to this block. On a mispredict the

---
 rtl/bp_pkg.sv | 32 +++
 rtl/bp_sat_counter.sv | 28 ++
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the fetch-stage branch predictor: counter
// encodings, saturating counter arithmetic and PC index/tag slicing.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctrState_e;

  // Saturating increment: ST holds at ST.
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  // Saturating decrement: SNT holds at SNT.
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  // Word index into the table; byte offset pc[1:0] is discarded.
  function automatic logic [31:0] pcIndex(input logic [31:0] pc, input int unsigned indexBits);
    return (pc >> 2) & ((32'd1 << indexBits) - 32'd1);
  endfunction

  // Everything above the index bits forms the stored tag.
  function automatic logic [31:0] pcTag(input logic [31:0] pc, input int unsigned indexBits);
    return pc >> (indexBits + 2);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One 2-bit saturating direction counter. load forces WT (fresh
// allocation); otherwise en with inc/dec steps the counter.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr
);

  // Counter state: reset to weakly-not-taken, load wins over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr <= WNT;
    end else if (load) begin
      ctr <= WT;
    end else if (en && inc) begin
      ctr <= sat_inc(ctr);
    end else if (en && dec) begin
      ctr <= sat_dec(ctr);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC generator: same-cycle direct-mapped BTB lookup with
// 2-bit counters, EX-stage mispredict detection/redirect and statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallF,
  input  logic [31:0] pcF,
  output logic        predTakenF,
  output logic [31:0] predTargetF,
  output logic [31:0] nextPCF,
  input  logic        updateEnE,
  input  logic [31:0] pcE,
  input  logic        takenE,
  input  logic [31:0] targetE,
  input  logic        predTakenE,
  input  logic [31:0] predTargetE,
  output logic        redirectE,
  output logic [31:0] redirectPCE,
  output logic [31:0] branchCnt,
  output logic [31:0] mispredCnt
);

  localparam int INDEX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;

  logic [INDEX_BITS-1:0] idxF;
  logic [INDEX_BITS-1:0] idxE;
  logic [TAG_BITS-1:0]   tagF;
  logic [TAG_BITS-1:0]   tagE;

  logic                  validArr [ENTRIES];
  logic [TAG_BITS-1:0]   tagArr   [ENTRIES];
  logic [31:0]           tgtArr   [ENTRIES];
  logic [ENTRIES-1:0][1:0] ctrArr;
  logic [ENTRIES-1:0]    entrySel;

  logic        hitF;
  logic        hitE;
  logic [31:0] pcPlus4F;
  logic [31:0] pcPlus4E;

  // The PC register itself honours the stall; redirects and updates must
  // proceed regardless, so the stall has no effect inside this block.
  logic unusedStall;
  assign unusedStall = StallF;

  assign idxF = INDEX_BITS'(pcIndex(pcF, INDEX_BITS));
  assign tagF = TAG_BITS'(pcTag(pcF, INDEX_BITS));
  assign idxE = INDEX_BITS'(pcIndex(pcE, INDEX_BITS));
  assign tagE = TAG_BITS'(pcTag(pcE, INDEX_BITS));

  assign pcPlus4F = pcF + 32'd4;
  assign pcPlus4E = pcE + 32'd4;

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign hitF        = validArr[idxF] && (tagArr[idxF] == tagF);
  assign predTakenF  = hitF && ctrArr[idxF][1];
  assign predTargetF = hitF ? tgtArr[idxF] : pcPlus4F;

  assign hitE = validArr[idxE] && (tagArr[idxE] == tagE);

  assign redirectE   = updateEnE && ((takenE != predTakenE) ||
                       (takenE && predTakenE && (targetE != predTargetE)));
  assign redirectPCE = takenE ? targetE : pcPlus4E;

  // A redirect always beats the prediction so a mispredict cannot be dropped.
  assign nextPCF = redirectE ? redirectPCE : (predTakenF ? predTargetF : pcPlus4F);

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : gEntry
      assign entrySel[gi] = updateEnE && (idxE == INDEX_BITS'(gi));

      bp_sat_counter uCtr (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (entrySel[gi] && hitE),
        .load (entrySel[gi] && !hitE && takenE),
        .inc  (takenE),
        .dec  (!takenE),
        .ctr  (ctrArr[gi])
      );
    end
  endgenerate

  // Valid/tag/target: refresh target on a taken hit, allocate on a taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validArr[i] <= 1'b0;
        tagArr[i]   <= '0;
        tgtArr[i]   <= '0;
      end
    end else if (updateEnE && takenE) begin
      validArr[idxE] <= 1'b1;
      tagArr[idxE]   <= tagE;
      tgtArr[idxE]   <= targetE;
    end
  end

  // Saturating statistics counters for resolved branches and mispredicts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else if (updateEnE) begin
      if (branchCnt != 32'hFFFF_FFFF) branchCnt <= branchCnt + 32'd1;
      if (redirectE && (mispredCnt != 32'hFFFF_FFFF)) mispredCnt <= mispredCnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0;
  logic [31:0] pcF = 32'h0;
  logic        predTakenF;
  logic [31:0] predTargetF;
  logic [31:0] nextPCF;
  logic        updateEnE = 1'b0;
  logic [31:0] pcE = 32'h0;
  logic        takenE = 1'b0;
  logic [31:0] targetE = 32'h0;
  logic        predTakenE = 1'b0;
  logic [31:0] predTargetE = 32'h0;
  logic        redirectE;
  logic [31:0] redirectPCE;
  logic [31:0] branchCnt;
  logic [31:0] mispredCnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .pcF(pcF),
    .predTakenF(predTakenF), .predTargetF(predTargetF), .nextPCF(nextPCF),
    .updateEnE(updateEnE), .pcE(pcE), .takenE(takenE), .targetE(targetE),
    .predTakenE(predTakenE), .predTargetE(predTargetE),
    .redirectE(redirectE), .redirectPCE(redirectPCE),
    .branchCnt(branchCnt), .mispredCnt(mispredCnt)
  );

  task automatic setUpd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                        input logic pt, input logic [31:0] ptg);
    updateEnE = 1'b1; pcE = pc; takenE = tk; targetE = tg; predTakenE = pt; predTargetE = ptg;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    updateEnE = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pcF = 32'h100;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; #1;
    checks++; if (predTakenF !== 1'b0) begin errors++; $display("FAIL reset_predTaken got=%b exp=0", predTakenF); end
    checks++; if (nextPCF !== 32'h104) begin errors++; $display("FAIL reset_nextPC got=%h exp=00000104", nextPCF); end
    checks++; if (predTargetF !== 32'h104) begin errors++; $display("FAIL reset_predTarget got=%h exp=00000104", predTargetF); end
    checks++; if (branchCnt !== 0 || mispredCnt !== 0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", branchCnt, mispredCnt); end
    $display("test_reset done: nextPCF=%h", nextPCF);
  endtask

  task automatic test_allocate();
    setUpd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    checks++; if (redirectE !== 1'b1) begin errors++; $display("FAIL alloc_redirect got=%b exp=1", redirectE); end
    checks++; if (redirectPCE !== 32'h200) begin errors++; $display("FAIL alloc_redirectPC got=%h exp=00000200", redirectPCE); end
    checks++; if (nextPCF !== 32'h200) begin errors++; $display("FAIL alloc_nextPC got=%h exp=00000200", nextPCF); end
    tick();
    checks++; if (predTakenF !== 1'b1) begin errors++; $display("FAIL alloc_hit got=%b exp=1", predTakenF); end
    checks++; if (nextPCF !== 32'h200) begin errors++; $display("FAIL alloc_hitNext got=%h exp=00000200", nextPCF); end
    checks++; if (branchCnt !== 1 || mispredCnt !== 1) begin errors++; $display("FAIL alloc_counts got=%0d/%0d exp=1/1", branchCnt, mispredCnt); end
    $display("test_allocate done: nextPCF=%h", nextPCF);
  endtask

  task automatic test_hysteresis();
    // WT -> WNT
    setUpd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    checks++; if (redirectE !== 1'b1 || redirectPCE !== 32'h104) begin errors++; $display("FAIL hyst_nt_redirect got=%b/%h exp=1/00000104", redirectE, redirectPCE); end
    tick();
    checks++; if (predTakenF !== 1'b0 || nextPCF !== 32'h104) begin errors++; $display("FAIL hyst_wnt got=%b/%h exp=0/00000104", predTakenF, nextPCF); end
    // WNT -> WT (mispredicted), WT -> ST (correct)
    setUpd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    tick();
    setUpd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    checks++; if (redirectE !== 1'b0) begin errors++; $display("FAIL hyst_correct_redirect got=%b exp=0", redirectE); end
    tick();
    checks++; if (predTakenF !== 1'b1) begin errors++; $display("FAIL hyst_st got=%b exp=1", predTakenF); end
    // ST -> WT, still predicts taken
    setUpd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    tick();
    checks++; if (predTakenF !== 1'b1 || nextPCF !== 32'h200) begin errors++; $display("FAIL hyst_wt got=%b/%h exp=1/00000200", predTakenF, nextPCF); end
    // Right direction, wrong target: redirect to the new target, target refreshed
    setUpd(32'h100, 1'b1, 32'h250, 1'b1, 32'h200);
    checks++; if (redirectE !== 1'b1 || redirectPCE !== 32'h250) begin errors++; $display("FAIL hyst_tgt_redirect got=%b/%h exp=1/00000250", redirectE, redirectPCE); end
    tick();
    checks++; if (predTargetF !== 32'h250) begin errors++; $display("FAIL hyst_tgt_update got=%h exp=00000250", predTargetF); end
    checks++; if (branchCnt !== 6 || mispredCnt !== 5) begin errors++; $display("FAIL hyst_counts got=%0d/%0d exp=6/5", branchCnt, mispredCnt); end
    $display("test_hysteresis done: counts=%0d/%0d", branchCnt, mispredCnt);
  endtask

  task automatic test_alias();
    pcF = 32'h140; #1;
    checks++; if (predTakenF !== 1'b0 || nextPCF !== 32'h144) begin errors++; $display("FAIL alias_miss got=%b/%h exp=0/00000144", predTakenF, nextPCF); end
    setUpd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    tick();
    checks++; if (predTakenF !== 1'b1 || predTargetF !== 32'h300) begin errors++; $display("FAIL alias_hit got=%b/%h exp=1/00000300", predTakenF, predTargetF); end
    pcF = 32'h100; #1;
    checks++; if (predTakenF !== 1'b0 || nextPCF !== 32'h104) begin errors++; $display("FAIL alias_old_miss got=%b/%h exp=0/00000104", predTakenF, nextPCF); end
    // A single not-taken drops a freshly allocated entry (WT) to WNT, target kept
    pcF = 32'h140;
    setUpd(32'h140, 1'b0, 32'h300, 1'b1, 32'h300);
    tick();
    checks++; if (predTakenF !== 1'b0 || predTargetF !== 32'h300) begin errors++; $display("FAIL alias_wt_alloc got=%b/%h exp=0/00000300", predTakenF, predTargetF); end
    $display("test_alias done: predTargetF=%h", predTargetF);
  endtask

  task automatic test_collision_stall();
    pcF = 32'h140;
    setUpd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
    checks++; if (predTakenF !== 1'b0) begin errors++; $display("FAIL coll_old_pred got=%b exp=0", predTakenF); end
    tick();
    checks++; if (predTakenF !== 1'b1) begin errors++; $display("FAIL coll_new_pred got=%b exp=1", predTakenF); end
    StallF = 1'b1;
    setUpd(32'h140, 1'b0, 32'h300, 1'b1, 32'h300);
    checks++; if (redirectE !== 1'b1 || nextPCF !== 32'h144) begin errors++; $display("FAIL stall_redirect got=%b/%h exp=1/00000144", redirectE, nextPCF); end
    tick();
    StallF = 1'b0;
    checks++; if (branchCnt !== 10 || mispredCnt !== 9) begin errors++; $display("FAIL stall_counts got=%0d/%0d exp=10/9", branchCnt, mispredCnt); end
    // Correctly predicted not-taken miss: no table change, no mispredict count
    setUpd(32'h180, 1'b0, 32'h400, 1'b0, 32'h184);
    checks++; if (redirectE !== 1'b0) begin errors++; $display("FAIL nt_miss_redirect got=%b exp=0", redirectE); end
    tick();
    checks++; if (predTargetF !== 32'h300 || predTakenF !== 1'b0) begin errors++; $display("FAIL nt_miss_nochange got=%b/%h exp=0/00000300", predTakenF, predTargetF); end
    checks++; if (branchCnt !== 11 || mispredCnt !== 9) begin errors++; $display("FAIL nt_miss_counts got=%0d/%0d exp=11/9", branchCnt, mispredCnt); end
    $display("test_collision_stall done: counts=%0d/%0d", branchCnt, mispredCnt);
  endtask

  task automatic test_async_reset();
    #2; rst_n = 1'b0; #1;
    checks++; if (branchCnt !== 0 || mispredCnt !== 0) begin errors++; $display("FAIL arst_counts got=%0d/%0d exp=0/0", branchCnt, mispredCnt); end
    checks++; if (predTargetF !== 32'h144 || nextPCF !== 32'h144) begin errors++; $display("FAIL arst_lookup got=%h/%h exp=00000144/00000144", predTargetF, nextPCF); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pcF = 32'h100; #1;
    checks++; if (predTakenF !== 1'b0 || nextPCF !== 32'h104) begin errors++; $display("FAIL arst_miss got=%b/%h exp=0/00000104", predTakenF, nextPCF); end
    $display("test_async_reset done: nextPCF=%h", nextPCF);
  endtask

  task automatic test_saturate_low();
    pcF = 32'h100;
    setUpd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);  // alloc WT
    tick();
    repeat (3) begin                                 // WNT, SNT, SNT (floor)
      setUpd(32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
      tick();
    end
    setUpd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);  // SNT -> WNT
    tick();
    checks++; if (predTakenF !== 1'b0) begin errors++; $display("FAIL sat_floor got=%b exp=0", predTakenF); end
    setUpd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);  // WNT -> WT
    tick();
    checks++; if (predTakenF !== 1'b1) begin errors++; $display("FAIL sat_recover got=%b exp=1", predTakenF); end
    $display("test_saturate_low done: counts=%0d/%0d", branchCnt, mispredCnt);
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_hysteresis();
    test_alias();
    test_collision_stall();
    test_async_reset();
    test_saturate_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
